// File: rtl/tribus_pkg.sv
// -----------------------------------------------------------------------------
// tribus_pkg
// Shared definitions for the tri-state bus arbiter:
//   - tribus_state_e : arbiter FSM states (IDLE, GRANT, TURN)
//   - TRIBUS_N_REQ / TRIBUS_TURN_CYC / TRIBUS_MAX_HOLD : default parameters
//   - tribus_idx_w() : width of an index/counter covering 0..n-1 (min 1 bit)
// -----------------------------------------------------------------------------
package tribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } tribus_state_e;

    localparam int TRIBUS_N_REQ    = 4;
    localparam int TRIBUS_TURN_CYC = 1;
    localparam int TRIBUS_MAX_HOLD = 16;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int tribus_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req_i upward starting at ptr_i,
// wrapping at N, and returns the first requester found.
// Ports:
//   req_i [N]     : request vector
//   ptr_i [IDX_W] : index with highest priority this round
//   win_o [N]     : one-hot winner (zero when no request)
//   idx_o [IDX_W] : index of the winner (zero when no request)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     win_o,
    output logic [IDX_W-1:0] idx_o
);

    // First requester at or after the pointer, with wrap-around.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        win_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < N; off++) begin
            cand     = (int'(ptr_i) + off) % N;
            cand_idx = IDX_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                win_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// -----------------------------------------------------------------------------
// tribus_arbiter
// Round-robin arbiter owning the bufif1 enables of a shared tri-state bus.
// At most one gnt bit is ever high, and every change of owner passes through
// TURN_CYC all-off cycles so two drivers can never overlap.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (clears gnt without a clock)
//   req      : request vector, one bit per requester
//   gnt      : registered one-hot-or-zero grant (drives bufif1 enables)
//   owner    : index of the current owner, meaningful only while bus_busy
//   bus_busy : high while any gnt bit is high
//   preempt  : one-cycle pulse when a grant is withdrawn by the hold limit
// Build option: define TRIBUS_TIMEOUT_EN to build the hold counter that
// preempts an owner after MAX_HOLD cycles while someone else is waiting.
// Without it preempt is tied low and a grant lasts until req[owner] falls.
// -----------------------------------------------------------------------------
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int N_REQ    = TRIBUS_N_REQ,
    parameter int TURN_CYC = TRIBUS_TURN_CYC,
    parameter int MAX_HOLD = TRIBUS_MAX_HOLD
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_REQ-1:0]                 req,
    output logic [N_REQ-1:0]                 gnt,
    output logic [tribus_idx_w(N_REQ)-1:0]   owner,
    output logic                             bus_busy,
    output logic                             preempt
);

    localparam int IDX_W = tribus_idx_w(N_REQ);
    localparam int TC_W  = tribus_idx_w(TURN_CYC);

    tribus_state_e    state_q,      state_d;
    logic [N_REQ-1:0] gnt_q,        gnt_d;
    logic [IDX_W-1:0] owner_q,      owner_d;
    logic [IDX_W-1:0] last_owner_q, last_owner_d;
    logic [TC_W-1:0]  turn_cnt_q,   turn_cnt_d;
    logic             bus_busy_q;

    logic [IDX_W-1:0] ptr_s;
    logic [N_REQ-1:0] win_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             timeout_s;

    // Priority starts one past the last owner, wrapping to index 0.
    always_comb begin
        if (last_owner_q == IDX_W'(N_REQ - 1)) begin
            ptr_s = '0;
        end else begin
            ptr_s = last_owner_q + IDX_W'(1);
        end
    end

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_s),
        .win_o (win_s),
        .idx_o (win_idx_s)
    );

`ifdef TRIBUS_TIMEOUT_EN
    localparam int HOLD_W = tribus_idx_w(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              preempt_q,  preempt_d;

    // Hold limit reached while some other requester is waiting.
    assign timeout_s = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) && ((req & ~gnt_q) != '0);

    // Hold counter: zero on entry to GRANT, counts while GRANT continues, saturates.
    always_comb begin
        if ((state_q == ST_GRANT) && (state_d == ST_GRANT)) begin
            if (hold_cnt_q != HOLD_W'(MAX_HOLD - 1)) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end else begin
            hold_cnt_d = '0;
        end
    end

    // A preemption is a timeout exit while the owner still requests.
    assign preempt_d = (state_q == ST_GRANT) && req[owner_q] && timeout_s;

    // Hold counter and preempt pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    logic unused_hold_s;

    assign timeout_s     = 1'b0;
    assign preempt       = 1'b0;
    assign unused_hold_s = (MAX_HOLD > 0);
`endif

    // FSM next state, grant, owner pointer and turnaround counter.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        turn_cnt_d   = turn_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    state_d      = ST_GRANT;
                    gnt_d        = win_s;
                    owner_d      = win_idx_s;
                    last_owner_d = win_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[owner_q] || timeout_s) begin
                    state_d    = ST_TURN;
                    gnt_d      = '0;
                    turn_cnt_d = '0;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_TURN: begin
                // Arbitration happens on the last turnaround cycle, so a
                // request that rose anywhere inside TURN is seen here.
                if (turn_cnt_q == TC_W'(TURN_CYC - 1)) begin
                    if (req != '0) begin
                        state_d      = ST_GRANT;
                        gnt_d        = win_s;
                        owner_d      = win_idx_s;
                        last_owner_d = win_idx_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + TC_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                turn_cnt_d = '0;
            end
        endcase
    end

    // State and output registers; reset drops every enable immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            turn_cnt_q   <= '0;
            bus_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            turn_cnt_q   <= turn_cnt_d;
            bus_busy_q   <= |gnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner    = owner_q;
    assign bus_busy = bus_busy_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tribus_arbiter
// Directed bench for tribus_arbiter with N_REQ=4, TURN_CYC=2, MAX_HOLD=4.
// Expectations for the timeout scenario follow TRIBUS_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_tribus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       bus_busy;
    logic       preempt;

    int n_cmp;
    int n_bad;

    tribus_arbiter #(
        .N_REQ    (4),
        .TURN_CYC (2),
        .MAX_HOLD (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .owner    (owner),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle and sample 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gnt(input string tag, input logic [3:0] exp);
        check_val(tag, {28'd0, gnt}, {28'd0, exp});
        check_val({tag, "_1hot"}, {31'd0, $onehot0(gnt)}, 32'd1);
        check_val({tag, "_busy"}, {31'd0, bus_busy}, {31'd0, (exp != 4'b0000)});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = 4'b0000;

        // Reset values
        #12;
        check_val("rst_gnt",     {28'd0, gnt},     32'd0);
        check_val("rst_owner",   {30'd0, owner},   32'd0);
        check_val("rst_busy",    {31'd0, bus_busy},32'd0);
        check_val("rst_preempt", {31'd0, preempt}, 32'd0);
        do_reset();

        // Single requester: grant one cycle later, release one cycle later
        req = 4'b0010;
        tick();
        check_gnt("single_gnt", 4'b0010);
        check_val("single_owner", {30'd0, owner}, 32'd1);
        req = 4'b0000;
        tick();
        check_gnt("single_rel", 4'b0000);
        tick();
        tick();
        check_gnt("single_idle", 4'b0000);

        // Simultaneous requests from reset: order 0,1,2,3 with 2-cycle gaps
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_gnt($sformatf("rr%0d_c1", k), 4'b0001 << k);
            check_val($sformatf("rr%0d_owner", k), {30'd0, owner}, k);
            tick();
            check_gnt($sformatf("rr%0d_c2", k), 4'b0001 << k);
            tick();
            check_gnt($sformatf("rr%0d_c3", k), 4'b0001 << k);
            req[k] = 1'b0;
            tick();
            check_gnt($sformatf("rr%0d_t1", k), 4'b0000);
            tick();
            check_gnt($sformatf("rr%0d_t2", k), 4'b0000);
        end
        tick();
        check_gnt("rr_idle", 4'b0000);

        // Late request during TURN: owner 2 releases, req[0] rises in TURN cycle 1
        req = 4'b0100;
        tick();
        check_gnt("late_g2", 4'b0100);
        check_val("late_owner2", {30'd0, owner}, 32'd2);
        req = 4'b0000;
        tick();
        check_gnt("late_t1", 4'b0000);
        req = 4'b0001;
        tick();
        check_gnt("late_t2", 4'b0000);
        tick();
        check_gnt("late_g0", 4'b0001);
        check_val("late_owner0", {30'd0, owner}, 32'd0);
        req = 4'b0000;
        tick();
        tick();
        tick();

        // Timeout: owner 0 holds, req[3] waits
        do_reset();
        req = 4'b0001;
        tick();
        check_gnt("to_c1", 4'b0001);
        req = 4'b1001;
        for (int c = 2; c <= 4; c++) begin
            tick();
            check_gnt($sformatf("to_c%0d", c), 4'b0001);
            check_val($sformatf("to_pre_c%0d", c), {31'd0, preempt}, 32'd0);
        end
        tick();
`ifdef TRIBUS_TIMEOUT_EN
        check_gnt("to_t1", 4'b0000);
        check_val("to_pre_t1", {31'd0, preempt}, 32'd1);
        tick();
        check_gnt("to_t2", 4'b0000);
        check_val("to_pre_t2", {31'd0, preempt}, 32'd0);
        tick();
        check_gnt("to_g3", 4'b1000);
        check_val("to_owner3", {30'd0, owner}, 32'd3);
`else
        for (int c = 5; c <= 12; c++) begin
            check_gnt($sformatf("nto_c%0d", c), 4'b0001);
            check_val($sformatf("nto_pre_c%0d", c), {31'd0, preempt}, 32'd0);
            tick();
        end
`endif
        req = 4'b0000;
        repeat (4) tick();
        check_gnt("to_end", 4'b0000);

        // Mid-grant reset clears gnt with no clock edge
        do_reset();
        req = 4'b0100;
        tick();
        check_gnt("mr_g2", 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mr_gnt_async",  {28'd0, gnt},      32'd0);
        check_val("mr_busy_async", {31'd0, bus_busy}, 32'd0);
        req = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_gnt("mr_first", 4'b0001);
        check_val("mr_owner", {30'd0, owner}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
